// File: rtl/antitheft_timer.sv
// ---------------------------------------------------------------------------
// antitheft_timer
//   Time base and programmable countdown serving the anti-theft alarm FSM.
//   A free-running divider produces a one-cycle tick every CLK_FREQ cycles.
//   The FSM requests a countdown with start_timer/interval; the selected
//   delay parameter is loaded and counted down once per tick, and expired
//   pulses for one cycle when it reaches zero. The four delay parameters
//   can be rewritten at run time through the reprogram port.
//
// Ports:
//   clock          in   system clock
//   reset          in   asynchronous, active-high reset
//   start_timer    in   load/run request (level, may be held)
//   interval[1:0]  in   parameter to load: 00 arm, 01 driver,
//                       10 passenger, 11 alarm-on
//   reprogram      in   single-cycle parameter write strobe
//   time_param_sel in   parameter index to write (same encoding)
//   time_value     in   new parameter value in seconds
//   one_hz_enable  out  one-cycle tick once per CLK_FREQ cycles
//   expired        out  one-cycle pulse when a countdown reaches zero
//   running        out  countdown active
//   remaining      out  seconds left in the active countdown
// ---------------------------------------------------------------------------
module antitheft_timer #(
  parameter int CLK_FREQ      = 50000000,
  parameter int DEF_ARM       = 6,
  parameter int DEF_DRIVER    = 8,
  parameter int DEF_PASSENGER = 15,
  parameter int DEF_ALARM     = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] interval,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  output logic       one_hz_enable,
  output logic       expired,
  output logic       running,
  output logic [3:0] remaining
);

  localparam int DIV_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_FREQ - 1);

  logic [DIV_W-1:0] divider_q, divider_d;
  logic             start_q;
  logic [1:0]       interval_q;
  logic [3:0]       params_q [4];
  logic [3:0]       remaining_q, remaining_d;
  logic             running_q, running_d;
  logic             expired_q, expired_d;
  logic             tick;
  logic             loadEvent;
  logic [3:0]       loadValue;

  // Tick is decoded straight from the divider register so it is glitch-free.
  assign tick = (divider_q == DIV_MAX);

  // A load is a rising start request, or a new interval while start is held.
  assign loadEvent = start_timer && (!start_q || (interval != interval_q));

  // The load reads the parameter as it stood before any same-cycle write.
  assign loadValue = params_q[interval];

  // Next-state logic for the divider and the countdown. A load takes
  // priority over a coincident tick: the divider restarts and no decrement
  // happens. A zero load finishes immediately without waiting for a tick.
  always_comb begin
    divider_d   = (loadEvent || tick) ? '0 : divider_q + 1'b1;
    remaining_d = remaining_q;
    running_d   = running_q;
    expired_d   = 1'b0;
    if (loadEvent) begin
      remaining_d = loadValue;
      running_d   = (loadValue != 4'd0);
      expired_d   = (loadValue == 4'd0);
    end else if (tick && running_q) begin
      if (remaining_q > 4'd1) begin
        remaining_d = remaining_q - 4'd1;
      end else begin
        remaining_d = 4'd0;
        running_d   = 1'b0;
        expired_d   = 1'b1;
      end
    end
  end

  // Countdown state and the registered copies of the FSM request inputs.
  // Reset aborts any countdown without producing an expired pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      divider_q   <= '0;
      start_q     <= 1'b0;
      interval_q  <= 2'b00;
      remaining_q <= 4'd0;
      running_q   <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      divider_q   <= divider_d;
      start_q     <= start_timer;
      interval_q  <= interval;
      remaining_q <= remaining_d;
      running_q   <= running_d;
      expired_q   <= expired_d;
    end
  end

  // User-reprogrammable delay parameters. Writes never touch the countdown
  // already in progress; they only affect later loads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      params_q[0] <= 4'(DEF_ARM);
      params_q[1] <= 4'(DEF_DRIVER);
      params_q[2] <= 4'(DEF_PASSENGER);
      params_q[3] <= 4'(DEF_ALARM);
    end else if (reprogram) begin
      params_q[time_param_sel] <= time_value;
    end
  end

  assign one_hz_enable = tick;
  assign expired       = expired_q;
  assign running       = running_q;
  assign remaining     = remaining_q;

endmodule

// File: tb/tb_antitheft_timer.sv
// ---------------------------------------------------------------------------
// tb_antitheft_timer
//   Directed bench for antitheft_timer with CLK_FREQ=4, so one tick every
//   four cycles. Expected values are hand-derived: for a countdown loaded
//   with N at edge 0, after edge k the remaining count is N - k/4 until
//   edge 4N, where expired is high for that one cycle and running drops.
// ---------------------------------------------------------------------------
module tb_antitheft_timer;

  logic       clock;
  logic       reset;
  logic       start_timer;
  logic [1:0] interval;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       one_hz_enable;
  logic       expired;
  logic       running;
  logic [3:0] remaining;

  int assertCount = 0;
  int failCount   = 0;

  antitheft_timer #(
    .CLK_FREQ(4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start_timer    (start_timer),
    .interval       (interval),
    .reprogram      (reprogram),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .one_hz_enable  (one_hz_enable),
    .expired        (expired),
    .running        (running),
    .remaining      (remaining)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drive one cycle of inputs, then advance to 1 time unit after the next
  // rising edge so outputs reflect that edge.
  task automatic applyStimulus(input logic st, input logic [1:0] iv,
                               input logic rp, input logic [1:0] sel,
                               input logic [3:0] val);
    start_timer    = st;
    interval       = iv;
    reprogram      = rp;
    time_param_sel = sel;
    time_value     = val;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_timer = 1'b0; interval = 2'b00;
    reprogram = 1'b0; time_param_sel = 2'b00; time_value = 4'd0;
    #12;
    assertCount++;
    if ({one_hz_enable, expired, running, remaining} !== 7'd0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got tick=%b exp=%b run=%b rem=%0d expected all 0",
               one_hz_enable, expired, running, remaining);
    end
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Single start pulse with the driver delay: 8 ticks, expiry at edge 32.
  task automatic test_basic_countdown();
    logic [3:0] expRem;
    applyStimulus(1'b1, 2'b01, 1'b0, 2'b00, 4'd0);
    assertCount++;
    if (remaining !== 4'd8 || running !== 1'b1 || expired !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL basic_load: got rem=%0d run=%b exp=%b expected rem=8 run=1 exp=0",
               remaining, running, expired);
    end
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(1'b0, 2'b01, 1'b0, 2'b00, 4'd0);
      expRem = (k < 32) ? 4'(8 - k / 4) : 4'd0;
      assertCount++;
      if (remaining !== expRem || running !== (k < 32) || expired !== (k == 32) ||
          one_hz_enable !== ((k % 4) == 3)) begin
        failCount++;
        $display("[TB] FAIL basic_count k=%0d: got rem=%0d run=%b exp=%b tick=%b expected rem=%0d run=%b exp=%b tick=%b",
                 k, remaining, running, expired, one_hz_enable, expRem, (k < 32), (k == 32), ((k % 4) == 3));
      end
    end
  endtask

  // Start held high for 40 cycles loads the arm delay once only.
  task automatic test_held_start();
    logic [3:0] expRem;
    int pulses;
    pulses = 0;
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
    assertCount++;
    if (remaining !== 4'd6 || running !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL held_load: got rem=%0d run=%b expected rem=6 run=1", remaining, running);
    end
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
      if (expired === 1'b1) pulses++;
      expRem = (k < 24) ? 4'(6 - k / 4) : 4'd0;
      assertCount++;
      if (remaining !== expRem || expired !== (k == 24) || running !== (k < 24)) begin
        failCount++;
        $display("[TB] FAIL held_count k=%0d: got rem=%0d exp=%b run=%b expected rem=%0d exp=%b run=%b",
                 k, remaining, expired, running, expRem, (k == 24), (k < 24));
      end
    end
    assertCount++;
    if (pulses != 1) begin
      failCount++;
      $display("[TB] FAIL held_pulses: got %0d expired pulses expected 1", pulses);
    end
    applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 4'd0);
  endtask

  // Interval changes from driver to alarm-on while start is held: reload.
  task automatic test_interval_change();
    logic [3:0] expRem;
    applyStimulus(1'b1, 2'b01, 1'b0, 2'b00, 4'd0);
    for (int k = 1; k <= 5; k++) applyStimulus(1'b1, 2'b01, 1'b0, 2'b00, 4'd0);
    assertCount++;
    if (remaining !== 4'd7) begin
      failCount++;
      $display("[TB] FAIL change_before: got rem=%0d expected 7", remaining);
    end
    applyStimulus(1'b1, 2'b11, 1'b0, 2'b00, 4'd0);
    assertCount++;
    if (remaining !== 4'd10 || running !== 1'b1 || one_hz_enable !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL change_reload: got rem=%0d run=%b tick=%b expected rem=10 run=1 tick=0",
               remaining, running, one_hz_enable);
    end
    for (int k = 1; k <= 44; k++) begin
      applyStimulus(1'b1, 2'b11, 1'b0, 2'b00, 4'd0);
      expRem = (k < 40) ? 4'(10 - k / 4) : 4'd0;
      assertCount++;
      if (remaining !== expRem || expired !== (k == 40) || one_hz_enable !== ((k % 4) == 3)) begin
        failCount++;
        $display("[TB] FAIL change_count k=%0d: got rem=%0d exp=%b tick=%b expected rem=%0d exp=%b tick=%b",
                 k, remaining, expired, one_hz_enable, expRem, (k == 40), ((k % 4) == 3));
      end
    end
    applyStimulus(1'b0, 2'b11, 1'b0, 2'b00, 4'd0);
  endtask

  // Parameter writes: a written value is used by later loads, a same-cycle
  // write does not affect the load, and a mid-count write is ignored.
  task automatic test_reprogram();
    logic [3:0] expRem;
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b10, 4'd3);
    applyStimulus(1'b1, 2'b10, 1'b0, 2'b00, 4'd0);
    assertCount++;
    if (remaining !== 4'd3) begin
      failCount++;
      $display("[TB] FAIL reprog_load: got rem=%0d expected 3", remaining);
    end
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b0, 2'b10, 1'b0, 2'b00, 4'd0);
      expRem = (k < 12) ? 4'(3 - k / 4) : 4'd0;
      assertCount++;
      if (remaining !== expRem || expired !== (k == 12)) begin
        failCount++;
        $display("[TB] FAIL reprog_count k=%0d: got rem=%0d exp=%b expected rem=%0d exp=%b",
                 k, remaining, expired, expRem, (k == 12));
      end
    end
    applyStimulus(1'b1, 2'b10, 1'b1, 2'b10, 4'd9);
    assertCount++;
    if (remaining !== 4'd3 || running !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL reprog_same_cycle: got rem=%0d run=%b expected rem=3 run=1", remaining, running);
    end
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b0, 2'b10, (k == 2), 2'b10, 4'd7);
      expRem = (k < 12) ? 4'(3 - k / 4) : 4'd0;
      assertCount++;
      if (remaining !== expRem || expired !== (k == 12)) begin
        failCount++;
        $display("[TB] FAIL reprog_active k=%0d: got rem=%0d exp=%b expected rem=%0d exp=%b",
                 k, remaining, expired, expRem, (k == 12));
      end
    end
    applyStimulus(1'b1, 2'b10, 1'b0, 2'b00, 4'd0);
    assertCount++;
    if (remaining !== 4'd7) begin
      failCount++;
      $display("[TB] FAIL reprog_later_load: got rem=%0d expected 7", remaining);
    end
    applyStimulus(1'b0, 2'b10, 1'b0, 2'b00, 4'd0);
  endtask

  // A load landing on a tick edge wins: full value, no decrement.
  task automatic test_load_on_tick();
    logic [3:0] expRem;
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
    for (int k = 1; k <= 3; k++) applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 4'd0);
    assertCount++;
    if (one_hz_enable !== 1'b1 || remaining !== 4'd6) begin
      failCount++;
      $display("[TB] FAIL tick_setup: got tick=%b rem=%0d expected tick=1 rem=6", one_hz_enable, remaining);
    end
    applyStimulus(1'b1, 2'b11, 1'b0, 2'b00, 4'd0);
    assertCount++;
    if (remaining !== 4'd10 || running !== 1'b1 || one_hz_enable !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL tick_load: got rem=%0d run=%b tick=%b expected rem=10 run=1 tick=0",
               remaining, running, one_hz_enable);
    end
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 2'b11, 1'b0, 2'b00, 4'd0);
      expRem = 4'(10 - k / 4);
      assertCount++;
      if (remaining !== expRem || one_hz_enable !== ((k % 4) == 3)) begin
        failCount++;
        $display("[TB] FAIL tick_count k=%0d: got rem=%0d tick=%b expected rem=%0d tick=%b",
                 k, remaining, one_hz_enable, expRem, ((k % 4) == 3));
      end
    end
  endtask

  // A zero driver delay expires in the cycle right after the load edge.
  task automatic test_zero_value();
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b01, 4'd0);
    applyStimulus(1'b1, 2'b01, 1'b0, 2'b00, 4'd0);
    assertCount++;
    if (running !== 1'b0 || expired !== 1'b1 || remaining !== 4'd0) begin
      failCount++;
      $display("[TB] FAIL zero_load: got run=%b exp=%b rem=%0d expected run=0 exp=1 rem=0",
               running, expired, remaining);
    end
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 2'b01, 1'b0, 2'b00, 4'd0);
      assertCount++;
      if (expired !== 1'b0 || running !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL zero_after k=%0d: got exp=%b run=%b expected exp=0 run=0", k, expired, running);
      end
    end
  endtask

  // Reset with 5 s left: outputs clear at once, no late expiry, and the
  // parameters return to their defaults.
  task automatic test_reset_mid_count();
    int pulses;
    pulses = 0;
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
    for (int k = 1; k <= 4; k++) applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 4'd0);
    assertCount++;
    if (remaining !== 4'd5 || running !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL midreset_setup: got rem=%0d run=%b expected rem=5 run=1", remaining, running);
    end
    #2 reset = 1'b1;
    #2;
    assertCount++;
    if ({one_hz_enable, expired, running, remaining} !== 7'd0) begin
      failCount++;
      $display("[TB] FAIL midreset_outputs: got tick=%b exp=%b run=%b rem=%0d expected all 0",
               one_hz_enable, expired, running, remaining);
    end
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 4'd0);
      if (expired === 1'b1) pulses++;
    end
    assertCount++;
    if (pulses != 0) begin
      failCount++;
      $display("[TB] FAIL midreset_no_expire: got %0d pulses expected 0", pulses);
    end
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
    assertCount++;
    if (remaining !== 4'd6) begin
      failCount++;
      $display("[TB] FAIL default_arm: got %0d expected 6", remaining);
    end
    applyStimulus(1'b1, 2'b01, 1'b0, 2'b00, 4'd0);
    assertCount++;
    if (remaining !== 4'd8) begin
      failCount++;
      $display("[TB] FAIL default_driver: got %0d expected 8", remaining);
    end
    applyStimulus(1'b1, 2'b10, 1'b0, 2'b00, 4'd0);
    assertCount++;
    if (remaining !== 4'd15) begin
      failCount++;
      $display("[TB] FAIL default_passenger: got %0d expected 15", remaining);
    end
    applyStimulus(1'b1, 2'b11, 1'b0, 2'b00, 4'd0);
    assertCount++;
    if (remaining !== 4'd10) begin
      failCount++;
      $display("[TB] FAIL default_alarm: got %0d expected 10", remaining);
    end
    applyStimulus(1'b0, 2'b11, 1'b0, 2'b00, 4'd0);
  endtask

  initial begin
    test_reset();
    test_basic_countdown();
    test_held_start();
    test_interval_change();
    test_reprogram();
    test_load_on_tick();
    test_zero_value();
    test_reset_mid_count();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/antitheft_timer.md
Name: antitheft_timer

Overview:
- Time base and programmable countdown for the automotive anti-theft controller; sits directly beside the alarm FSM and serves it.
- Consumes the FSM's `start_timer` and `interval[1:0]` outputs and produces the `expired` and `one_hz_enable` inputs the FSM samples.
- Holds four user-reprogrammable delay parameters (arm, driver, passenger, alarm-on) and counts the selected one down at 1 Hz.

Parameters:
- CLK_FREQ, 50000000, clock cycles per one-second tick.
- DEF_ARM, 6, reset value of T_ARM_DELAY (s).
- DEF_DRIVER, 8, reset value of T_DRIVER_DELAY (s).
- DEF_PASSENGER, 15, reset value of T_PASSENGER_DELAY (s).
- DEF_ALARM, 10, reset value of T_ALARM_ON (s).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start_timer  in  1  load/run request from the FSM; level, may be held for many cycles.
- interval  in  2  parameter select for the load: 00 arm, 01 driver, 10 passenger, 11 alarm-on.
- reprogram  in  1  single-cycle write strobe for a parameter register.
- time_param_sel  in  2  parameter index to write; same encoding as interval.
- time_value  in  4  new parameter value in seconds.
- one_hz_enable  out  1  one-cycle tick, once per CLK_FREQ cycles.
- expired  out  1  one-cycle pulse when a countdown reaches zero.
- running  out  1  countdown active.
- remaining  out  4  seconds left in the active countdown.

Behaviour:
- Reset (async) values: divider=0, one_hz_enable=0, expired=0, running=0, remaining=0, start_d=0, interval_d=00. Parameter registers reload DEF_*. Reset mid-countdown aborts the countdown, with no expired pulse.
- Divider: counter runs 0..CLK_FREQ-1 and wraps. one_hz_enable = (divider==CLK_FREQ-1), decoded from the register, so it is glitch-free. It is free-running; the FSM also uses it for status blinking.
- Load event: the cycle where start_timer=1 AND (start_d=0 OR interval!=interval_d).
  - start_d and interval_d are registered copies of the inputs.
  - Holding start_timer high does not reload.
  - A changed interval while start_timer is held does reload.
- On a load event, at the next edge: remaining <= param[interval], divider <= 0, running <= 1, expired <= 0.
- Counting: on a cycle with one_hz_enable=1, running=1 and no load event:
  - if remaining>1: remaining-1;
  - if remaining==1: remaining <= 0, running <= 0, expired <= 1 for exactly one cycle.
- Loaded value 0: running <= 0 and expired pulses in the cycle immediately after the load edge. No tick is needed.
- Timing rule: for a loaded value N≥1, expired is high during the cycle following the N-th tick after load, i.e. cycle N*CLK_FREQ+1 counted from the load edge.
- start_timer deasserted mid-count: the countdown continues. The FSM's wait states rely on this. Only reset or a new load event stops or restarts it.
- Reprogram: when reprogram=1, param[time_param_sel] <= time_value at the edge.
  - A write does not affect an active countdown.
  - If a write and a load event target the same index in the same cycle, the load uses the pre-write value.
- Simultaneous load event and tick: the load wins; the divider restarts at 0 and there is no decrement.
- expired while running=0 never repeats; it is a pulse only, never a level.
- Width rules: remaining is 4 bits and never underflows below 0. The divider width is $clog2(CLK_FREQ).

Test Plan:
1. Reset defaults, CLK_FREQ=4: pulse start_timer with interval=01 -> remaining=8; ticks every 4 cycles; expired high for exactly one cycle at cycle 33 after the load edge; running then 0.
2. Held start: start_timer held high for 40 cycles with interval=00 -> single load of 6; no reload; remaining decrements 6→0; one expired pulse.
3. Interval change while held: start high with interval=01, then after 5 cycles interval=11 -> reload to 10 with divider restarted; expired only after 10 further ticks.
4. Reprogram: write time_param_sel=10, time_value=3, then load with interval=10 -> expired after 3 ticks. Write index 10 during an active countdown on index 10 -> remaining unaffected.
5. Zero value: program driver=0, load interval=01 -> running stays 0 and expired pulses in the cycle after the load.
6. Reset mid-count with remaining=5 -> outputs zero immediately, parameters return to 6/8/15/10, and no expired pulse follows.
